parallel_adc_emulator: RTL and testbench
========================================

Name: parallel_adc_emulator

Overview:
- Synthesisable responder model of the 8-bit parallel-bus ADC that the FPGA ADC interface drives.
- Sits on the device side of the CONVST/EOC/CS/RD/A/DB bus. Used in loop-back builds and benches so the interface can run without the physical converter.
- Per-channel sample registers supply the conversion data. Each register can be preloaded over a config port and can optionally ramp after every conversion.

Parameters:
- CONV_CYCLES, 2, clocks from detected CONVST falling edge to EOC assertion (legal range 1..255).
- EOC_CYCLES, 1, clocks EOC is held low (legal range 1..255).
- SYNC_STAGES, 2, flip-flop stages on CONVST/CS/RD inputs (legal range 2..3).
- CH_OFFSET, 32, reset value step between channel registers: reset value of reg[n] = n*CH_OFFSET mod 256.
- RAMP_STEP, 1, added mod 256 to a channel register after each conversion of that channel when RAMP_EN=1.

Ports:
- CLK_8MHZ  input  1  system clock
- RESET_N  input  1  asynchronous, active-low reset
- CONVST  input  1  active-low conversion start; a falling edge starts a conversion
- CS  input  1  active-low chip select
- RD  input  1  active-low read strobe
- A  input  3  channel address, sampled at conversion start
- EOC  output  1  active-low end of conversion
- DB  output  8  conversion data
- DB_OE  output  1  high when the device would drive DB (external tristate control)
- RAMP_EN  input  1  enables per-conversion ramp of the converted channel
- CFG_WE  input  1  one-cycle write strobe for a channel register
- CFG_ADDR  input  3  channel register index
- CFG_DATA  input  8  channel register write value
- CLR_OVR  input  1  clears OVERRUN
- BUSY  output  1  high while in CONVERT or EOC_LOW
- OVERRUN  output  1  sticky flag: a start was ignored
- CONV_COUNT  output  16  number of completed conversions, wraps at 65535->0

Behaviour:
- Reset (RESET_N low, asynchronous) forces: EOC=1, DB=0, DB_OE=0, BUSY=0, OVERRUN=0, CONV_COUNT=0, state IDLE, synchronisers to 1, and every reg[n] to its CH_OFFSET value.
- Reset asserted mid-conversion aborts the conversion immediately. No EOC pulse is produced afterwards.
- CONVST, CS and RD are passed through SYNC_STAGES flip-flops before use. A start is a synchronised 1->0 transition of CONVST.
- State IDLE:
  - On a start, latch A into ach, load cnt=CONV_CYCLES-1, set BUSY=1, go to CONVERT.
- State CONVERT:
  - When cnt reaches 0: DB <= reg[ach], EOC <= 0, cnt <= EOC_CYCLES-1, go to EOC_LOW.
  - Otherwise decrement cnt.
  - First EOC-low cycle is CONV_CYCLES clocks after the clock that detects the start.
- Ramp update: in the same clock that DB is loaded, reg[ach] <= reg[ach]+RAMP_STEP (8-bit wrap, 0xFF+1 -> 0x00), only if RAMP_EN=1.
- State EOC_LOW:
  - When cnt reaches 0: EOC <= 1, CONV_COUNT increments, BUSY <= 0, go to IDLE.
- DB keeps its value until the next conversion reloads it. It is therefore stable across the rising edge of EOC, which the interface uses as its capture edge.
- DB_OE = synchronised CS low AND synchronised RD low. It is independent of state.
- A start detected in CONVERT or EOC_LOW is ignored and sets OVERRUN=1. A start detected in the same cycle the FSM returns to IDLE is also ignored and flagged.
- OVERRUN clears on CLR_OVR=1. If a set and a clear occur in the same cycle, the set wins.
- Config writes: CFG_WE=1 writes CFG_DATA to reg[CFG_ADDR].
  - Writes are allowed in any state.
  - If a write and a ramp update target the same register in the same cycle, the write wins.
  - A write to the channel being converted before DB is loaded is reflected in DB.
- A and CFG_* are synchronous to CLK_8MHZ. A is only sampled at start.
- Start-to-EOC-low latency from the pin = SYNC_STAGES+1+CONV_CYCLES clocks (5 with the defaults).

Test Plan:
- Reset release, RAMP_EN=0, A=3, single CONVST low pulse of 4 clocks -> EOC low for exactly 1 clock starting 5 clocks after the CONVST fall; DB=0x60 through EOC rise; CONV_COUNT=1.
- RAMP_EN=1, A=7, reg[7] preset to 0xFF via CFG, three conversions -> DB sequence 0xFF, 0x00, 0x01; reg[7] ends at 0x02.
- Second CONVST fall 2 clocks after the first, defaults -> ignored; only one EOC pulse; OVERRUN=1; CLR_OVR pulse -> OVERRUN=0.
- CFG_WE to reg[2]=0xA5 in the same cycle a ramp update of reg[2] occurs -> reg[2]=0xA5; next conversion of channel 2 returns 0xA5.
- RESET_N pulsed low while in CONVERT -> EOC stays 1, BUSY=0, CONV_COUNT=0, all regs back to n*32; the next start behaves as after power-up.
- CS=RD=0 held for 6 clocks then released -> DB_OE high from 2 clocks after the fall until 2 clocks after the release; DB value unchanged.

Source files
------------

// File: rtl/parallel_adc_emulator.sv
`default_nettype none
// ============================================================================
// Module   : parallel_adc_emulator
// Brief    : Device-side responder for an 8-bit parallel-bus ADC (CONVST/EOC/
//            CS/RD/A/DB) with preloadable, optionally ramping channel registers.
// Revision : 1.0
// ============================================================================
module parallel_adc_emulator #(
    parameter int CONV_CYCLES = 2,
    parameter int EOC_CYCLES  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CH_OFFSET   = 32,
    parameter int RAMP_STEP   = 1
) (
    input  logic        CLK_8MHZ,
    input  logic        RESET_N,
    input  logic        CONVST,
    input  logic        CS,
    input  logic        RD,
    input  logic [2:0]  A,
    output logic        EOC,
    output logic [7:0]  DB,
    output logic        DB_OE,
    input  logic        RAMP_EN,
    input  logic        CFG_WE,
    input  logic [2:0]  CFG_ADDR,
    input  logic [7:0]  CFG_DATA,
    input  logic        CLR_OVR,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic [15:0] CONV_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EOC_LOW = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] convst_sync_q, convst_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic                   convst_prev_q, convst_prev_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             ach_q, ach_d;
    logic [7:0]             db_q, db_d;
    logic                   eoc_q, eoc_d;
    logic                   ovr_q, ovr_d;
    logic [15:0]            count_q, count_d;
    logic [7:0]             regs_q [8];
    logic [7:0]             regs_d [8];
    logic                   start;

    always_comb begin
        convst_sync_d = {convst_sync_q[SYNC_STAGES-2:0], CONVST};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], CS};
        rd_sync_d     = {rd_sync_q[SYNC_STAGES-2:0], RD};
        convst_prev_d = convst_sync_q[SYNC_STAGES-1];
    end

    // Start = synchronised falling edge of CONVST.
    assign start = convst_prev_q & ~convst_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ach_d   = ach_q;
        db_d    = db_q;
        eoc_d   = eoc_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        regs_d  = regs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ach_d   = A;
                    cnt_d   = 8'(CONV_CYCLES - 1);
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt_q == 8'd0) begin
                    db_d    = regs_q[ach_q];
                    eoc_d   = 1'b0;
                    cnt_d   = 8'(EOC_CYCLES - 1);
                    state_d = S_EOC_LOW;
                    if (RAMP_EN) begin
                        regs_d[ach_q] = regs_q[ach_q] + 8'(RAMP_STEP);
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_EOC_LOW: begin
                if (cnt_q == 8'd0) begin
                    eoc_d   = 1'b1;
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Config write after the ramp so a same-cycle write takes priority.
        if (CFG_WE) begin
            regs_d[CFG_ADDR] = CFG_DATA;
        end
        if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
        if (start && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_8MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            convst_sync_q <= '1;
            cs_sync_q     <= '1;
            rd_sync_q     <= '1;
            convst_prev_q <= 1'b1;
            cnt_q         <= 8'd0;
            ach_q         <= 3'd0;
            db_q          <= 8'd0;
            eoc_q         <= 1'b1;
            ovr_q         <= 1'b0;
            count_q       <= 16'd0;
            for (int n = 0; n < 8; n++) begin
                regs_q[n] <= 8'(n * CH_OFFSET);
            end
        end else begin
            state_q       <= state_d;
            convst_sync_q <= convst_sync_d;
            cs_sync_q     <= cs_sync_d;
            rd_sync_q     <= rd_sync_d;
            convst_prev_q <= convst_prev_d;
            cnt_q         <= cnt_d;
            ach_q         <= ach_d;
            db_q          <= db_d;
            eoc_q         <= eoc_d;
            ovr_q         <= ovr_d;
            count_q       <= count_d;
            regs_q        <= regs_d;
        end
    end

    assign EOC        = eoc_q;
    assign DB         = db_q;
    assign DB_OE      = ~cs_sync_q[SYNC_STAGES-1] & ~rd_sync_q[SYNC_STAGES-1];
    assign BUSY       = (state_q != S_IDLE);
    assign OVERRUN    = ovr_q;
    assign CONV_COUNT = count_q;

endmodule
`default_nettype wire

// File: tb/tb_parallel_adc_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_parallel_adc_emulator
// Brief    : Directed + randomized bench with a timeline-based reference model.
// Revision : 1.0
// ============================================================================
module tb_parallel_adc_emulator;

    localparam int CONV_CYCLES = 2;
    localparam int EOC_CYCLES  = 1;
    localparam int SYNC_STAGES = 2;
    localparam int CH_OFFSET   = 32;
    localparam int RAMP_STEP   = 1;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        CONVST, CS, RD;
    logic [2:0]  A;
    logic        EOC;
    logic [7:0]  DB;
    logic        DB_OE;
    logic        RAMP_EN, CFG_WE, CLR_OVR;
    logic [2:0]  CFG_ADDR;
    logic [7:0]  CFG_DATA;
    logic        BUSY, OVERRUN;
    logic [15:0] CONV_COUNT;

    int errors = 0;
    int checks = 0;

    parallel_adc_emulator #(
        .CONV_CYCLES(CONV_CYCLES), .EOC_CYCLES(EOC_CYCLES), .SYNC_STAGES(SYNC_STAGES),
        .CH_OFFSET(CH_OFFSET), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .CLK_8MHZ(clk), .RESET_N(RESET_N), .CONVST(CONVST), .CS(CS), .RD(RD), .A(A),
        .EOC(EOC), .DB(DB), .DB_OE(DB_OE), .RAMP_EN(RAMP_EN), .CFG_WE(CFG_WE),
        .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CLR_OVR(CLR_OVR), .BUSY(BUSY),
        .OVERRUN(OVERRUN), .CONV_COUNT(CONV_COUNT)
    );

    always #5 clk = ~clk;

    // Reference model: m_e = clocks elapsed since a start was accepted (-1 when idle).
    int          m_e;
    logic [7:0]  m_reg [8];
    logic [7:0]  m_db;
    logic [2:0]  m_ach;
    logic        m_ovr;
    logic [15:0] m_cnt;
    logic        m_cv [6];
    logic        m_cs [6];
    logic        m_rd [6];

    always @(posedge clk or negedge RESET_N) begin
        bit was_busy;
        bit start;
        if (!RESET_N) begin
            m_e = -1; m_db = 8'h00; m_ach = 3'd0; m_ovr = 1'b0; m_cnt = 16'd0;
            for (int n = 0; n < 8; n++) m_reg[n] = 8'((n * CH_OFFSET) % 256);
            for (int i = 0; i < 6; i++) begin m_cv[i] = 1'b1; m_cs[i] = 1'b1; m_rd[i] = 1'b1; end
        end else begin
            for (int i = 5; i > 0; i--) begin
                m_cv[i] = m_cv[i-1]; m_cs[i] = m_cs[i-1]; m_rd[i] = m_rd[i-1];
            end
            m_cv[0] = CONVST; m_cs[0] = CS; m_rd[0] = RD;
            start = (m_cv[SYNC_STAGES] == 1'b0) && (m_cv[SYNC_STAGES+1] == 1'b1);
            was_busy = (m_e >= 0);
            if (was_busy) begin
                m_e = m_e + 1;
                if (m_e == CONV_CYCLES) begin
                    m_db = m_reg[m_ach];
                    if (RAMP_EN) m_reg[m_ach] = m_reg[m_ach] + 8'(RAMP_STEP);
                end
                if (m_e == CONV_CYCLES + EOC_CYCLES) begin
                    m_e = -1;
                    m_cnt = m_cnt + 16'd1;
                end
            end
            if (CFG_WE) m_reg[CFG_ADDR] = CFG_DATA;
            if (CLR_OVR) m_ovr = 1'b0;
            if (start) begin
                if (was_busy) m_ovr = 1'b1;
                else begin m_e = 0; m_ach = A; end
            end
        end
    end

    always @(negedge clk) begin
        logic [27:0] exp_v, act_v;
        exp_v = {!(m_e >= CONV_CYCLES), m_db,
                 (!m_cs[SYNC_STAGES-1] && !m_rd[SYNC_STAGES-1]), (m_e >= 0), m_ovr, m_cnt};
        act_v = {EOC, DB, DB_OE, BUSY, OVERRUN, CONV_COUNT};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t: {EOC,DB,OE,BUSY,OVR,CNT} got %0h expected %0h",
                     $time, act_v, exp_v);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input logic [2:0] ch, output logic [7:0] d);
        int n;
        A = ch; CONVST = 1'b0;
        tick(2);
        CONVST = 1'b1;
        n = 0;
        while (EOC !== 1'b0 && n < 20) begin tick(1); n++; end
        check("conv_eoc_low", {31'd0, EOC}, 32'd0);
        d = DB;
        n = 0;
        while (BUSY !== 1'b0 && n < 20) begin tick(1); n++; end
        check("conv_done", {31'd0, BUSY}, 32'd0);
        tick(2);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] db0;
        logic [7:0] eoc_pat;
        logic [9:0] oe_pat;
        int         low_cnt;

        RESET_N = 1'b0; CONVST = 1'b1; CS = 1'b1; RD = 1'b1; A = 3'd0;
        RAMP_EN = 1'b0; CFG_WE = 1'b0; CFG_ADDR = 3'd0; CFG_DATA = 8'd0; CLR_OVR = 1'b0;
        tick(3);
        check("rst_eoc", {31'd0, EOC}, 32'd1);
        check("rst_db", {24'd0, DB}, 32'd0);
        check("rst_oe_busy_ovr", {29'd0, DB_OE, BUSY, OVERRUN}, 32'd0);
        check("rst_count", {16'd0, CONV_COUNT}, 32'd0);
        RESET_N = 1'b1;
        tick(2);

        // Single conversion of channel 3: EOC low exactly on the 5th clock after the fall.
        A = 3'd3; CONVST = 1'b0; eoc_pat = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            eoc_pat[k-1] = ~EOC;
            if (k == 5 || k == 6) check("s1_db", {24'd0, DB}, 32'h60);
            if (k == 4) CONVST = 1'b1;
        end
        check("s1_eoc_pattern", {24'd0, eoc_pat}, 32'h10);
        check("s1_count", {16'd0, CONV_COUNT}, 32'd1);

        // Ramp wrap on channel 7.
        tick(2);
        RAMP_EN = 1'b1; CFG_WE = 1'b1; CFG_ADDR = 3'd7; CFG_DATA = 8'hFF;
        tick(1);
        CFG_WE = 1'b0;
        do_conv(3'd7, d); check("s2_db0", {24'd0, d}, 32'hFF);
        do_conv(3'd7, d); check("s2_db1", {24'd0, d}, 32'h00);
        do_conv(3'd7, d); check("s2_db2", {24'd0, d}, 32'h01);
        RAMP_EN = 1'b0;
        do_conv(3'd7, d); check("s2_reg7", {24'd0, d}, 32'h02);

        // Second fall two clocks after the first is ignored and flagged.
        CLR_OVR = 1'b1; tick(1); CLR_OVR = 1'b0;
        check("s3_ovr_pre", {31'd0, OVERRUN}, 32'd0);
        A = 3'd1; CONVST = 1'b0; low_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (EOC == 1'b0) low_cnt++;
            if (k == 1) CONVST = 1'b1;
            if (k == 2) CONVST = 1'b0;
            if (k == 4) CONVST = 1'b1;
        end
        check("s3_eoc_pulses", low_cnt, 32'd1);
        check("s3_ovr_set", {31'd0, OVERRUN}, 32'd1);
        check("s3_count", {16'd0, CONV_COUNT}, 32'd6);
        CLR_OVR = 1'b1; tick(1); CLR_OVR = 1'b0;
        check("s3_ovr_clr", {31'd0, OVERRUN}, 32'd0);

        // Config write collides with ramp of channel 2; the write wins.
        tick(2);
        RAMP_EN = 1'b1; A = 3'd2; CONVST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 2) CONVST = 1'b1;
            if (k == 4) begin CFG_WE = 1'b1; CFG_ADDR = 3'd2; CFG_DATA = 8'hA5; end
            if (k == 5) begin CFG_WE = 1'b0; check("s4_db_old", {24'd0, DB}, 32'h40); end
        end
        RAMP_EN = 1'b0;
        tick(2);
        do_conv(3'd2, d); check("s4_db_written", {24'd0, d}, 32'hA5);

        // Reset in the middle of CONVERT.
        A = 3'd4; CONVST = 1'b0;
        tick(2);
        CONVST = 1'b1;
        tick(2);
        check("s5_busy_pre", {31'd0, BUSY}, 32'd1);
        RESET_N = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        low_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (EOC == 1'b0) low_cnt++;
        end
        check("s5_no_eoc", low_cnt, 32'd0);
        check("s5_busy", {31'd0, BUSY}, 32'd0);
        check("s5_count", {16'd0, CONV_COUNT}, 32'd0);
        do_conv(3'd5, d); check("s5_reg5", {24'd0, d}, 32'hA0);
        do_conv(3'd2, d); check("s5_reg2", {24'd0, d}, 32'h40);
        check("s5_count_after", {16'd0, CONV_COUNT}, 32'd2);

        // DB_OE follows synchronised CS/RD with two clocks of latency each way.
        tick(2);
        db0 = DB; CS = 1'b0; RD = 1'b0; oe_pat = 10'd0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            oe_pat[k-1] = DB_OE;
            if (k == 6) begin CS = 1'b1; RD = 1'b1; end
        end
        check("s6_oe_pattern", {22'd0, oe_pat}, 32'h07E);
        check("s6_db_stable", {24'd0, DB}, {24'd0, db0});

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ($urandom_range(0, 4) == 0) CONVST = ~CONVST;
            CS       = 1'($urandom_range(0, 1));
            RD       = 1'($urandom_range(0, 1));
            A        = 3'($urandom_range(0, 7));
            RAMP_EN  = ($urandom_range(0, 2) != 0);
            CFG_WE   = ($urandom_range(0, 7) == 0);
            CFG_ADDR = 3'($urandom_range(0, 7));
            CFG_DATA = 8'($urandom_range(0, 255));
            CLR_OVR  = ($urandom_range(0, 15) == 0);
        end
        CFG_WE = 1'b0; CLR_OVR = 1'b0; CONVST = 1'b1;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
